// File: rtl/fxmul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fxmul_pkg
//  Description : Shared definitions for the fxmul_arbiter block: controller
//                state encoding, default datapath constants and the width of
//                the completed-operation counter.
//  Ports       : (package, no ports)
//  Revision    : 1.0 - initial release
// ============================================================================
package fxmul_pkg;

  // Default configuration of the block.
  localparam int c_data_w_def    = 32;
  localparam int c_frac_bits_def = 12;
  localparam int c_mul_lat_def   = 2;

  // Width of the wrapping completed-response counter.
  localparam int c_ops_w = 16;

  // Multiply-phase down-counter width; holds MUL_LAT-1 for MUL_LAT up to 4.
  localparam int c_cnt_w = 3;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage : fxmul_pkg
`default_nettype wire

// File: rtl/fxmul_core.sv
`default_nettype none
// ============================================================================
//  Module      : fxmul_core
//  Description : Pipelined signed fixed-point multiplier. The full-width
//                product of the operands is captured when load_i is high and
//                then travels through MUL_LAT register stages. The last stage
//                is arithmetically shifted right by FRAC_BITS (floor) and
//                reduced to DATA_W bits.
//                Optional feature macro: FXMUL_ARBITER_SAT_EN
//                  defined   -> out-of-range results clamp to the signed
//                               DATA_W maximum / minimum
//                  undefined -> low DATA_W bits are kept (wrap)
//  Ports       : clock   - rising-edge clock
//                reset   - synchronous, active-low
//                load_i  - capture a new product into the first stage
//                a_i/b_i - signed operands, DATA_W bits
//                res_o   - result of the operands loaded MUL_LAT cycles ago
//  Revision    : 1.0 - initial release
// ============================================================================
module fxmul_core
  import fxmul_pkg::*;
#(
  parameter int DATA_W    = c_data_w_def,
  parameter int FRAC_BITS = c_frac_bits_def,
  parameter int MUL_LAT   = c_mul_lat_def
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] res_o
);

  localparam int c_pw = 2 * DATA_W;

  logic signed [c_pw-1:0] w_a_ext;
  logic signed [c_pw-1:0] w_b_ext;
  logic signed [c_pw-1:0] w_prod;
  logic signed [c_pw-1:0] w_shifted;
  logic signed [c_pw-1:0] pipe_q [MUL_LAT];

  // Sign-extend to the product width so the multiply is a true signed one.
  assign w_a_ext = {{DATA_W{a_i[DATA_W-1]}}, a_i};
  assign w_b_ext = {{DATA_W{b_i[DATA_W-1]}}, b_i};
  assign w_prod  = w_a_ext * w_b_ext;

  // Stage 0 only changes on a new operation; later stages simply follow, so
  // the last stage holds the loaded product exactly MUL_LAT cycles later.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      if (load_i) begin
        pipe_q[0] <= w_prod;
      end
      for (int i = 1; i < MUL_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Arithmetic shift on a signed operand gives floor division by 2^FRAC_BITS.
  assign w_shifted = pipe_q[MUL_LAT-1] >>> FRAC_BITS;

`ifdef FXMUL_ARBITER_SAT_EN
  logic w_ovf;

  // The value fits in DATA_W signed bits only if every bit from DATA_W-1
  // upwards equals the sign bit.
  assign w_ovf = (w_shifted[c_pw-1:DATA_W-1] != {(DATA_W+1){w_shifted[c_pw-1]}});

  always_comb begin
    res_o = w_shifted[DATA_W-1:0];
    if (w_ovf) begin
      res_o = w_shifted[c_pw-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  // Upper product bits are intentionally dropped by the wrap behaviour.
  logic w_unused_hi;

  assign res_o       = w_shifted[DATA_W-1:0];
  assign w_unused_hi = ^w_shifted[c_pw-1:DATA_W];
`endif

endmodule : fxmul_core
`default_nettype wire

// File: rtl/fxmul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fxmul_arbiter
//  Description : Two requesters share one pipelined signed fixed-point
//                multiplier. One operation is in flight at a time; requests
//                are granted round-robin in IDLE, the multiply runs for
//                MUL_LAT cycles, and the result is held on the granted
//                port's response channel until it is accepted.
//                Optional feature macro: FXMUL_ARBITER_SAT_EN (saturate
//                results instead of wrapping; see fxmul_core).
//  Ports       : clock                     - rising-edge clock
//                reset                     - synchronous, active-low
//                req{0,1}_valid/_ready     - request handshake
//                req{0,1}_a/_b             - signed operands
//                resp{0,1}_valid/_ready    - response handshake
//                resp{0,1}_data            - signed result
//                ops_done                  - wrapping count of responses
//  Parameters  : DATA_W (operand width), FRAC_BITS (fraction bits dropped),
//                MUL_LAT (multiplier stages, 1..4)
//  Revision    : 1.0 - initial release
// ============================================================================
module fxmul_arbiter
  import fxmul_pkg::*;
#(
  parameter int DATA_W    = c_data_w_def,
  parameter int FRAC_BITS = c_frac_bits_def,
  parameter int MUL_LAT   = c_mul_lat_def
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [DATA_W-1:0]  req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [DATA_W-1:0]  req1_b,
  output logic               resp0_valid,
  input  logic               resp0_ready,
  output logic [DATA_W-1:0]  resp0_data,
  output logic               resp1_valid,
  input  logic               resp1_ready,
  output logic [DATA_W-1:0]  resp1_data,
  output logic [c_ops_w-1:0] ops_done
);

  state_e               state_q, state_d;
  logic                 last_q, last_d;   // index of the port granted last
  logic                 gnt_q, gnt_d;     // port owning the in-flight operation
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [c_ops_w-1:0]   ops_q, ops_d;
  logic [DATA_W-1:0]    rdata0_q, rdata1_q;

  logic                 w_any;
  logic                 w_sel;
  logic                 w_load;
  logic                 w_dload;
  logic [DATA_W-1:0]    w_a;
  logic [DATA_W-1:0]    w_b;
  logic [DATA_W-1:0]    w_res;

  // Round-robin pick: on contention the port not granted last wins,
  // otherwise whichever port is asking.
  assign w_any = req0_valid | req1_valid;
  assign w_sel = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  assign w_a   = w_sel ? req1_a : req0_a;
  assign w_b   = w_sel ? req1_b : req0_b;

  fxmul_core #(
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS),
    .MUL_LAT   (MUL_LAT)
  ) u_core (
    .clock  (clock),
    .reset  (reset),
    .load_i (w_load),
    .a_i    (w_a),
    .b_i    (w_b),
    .res_o  (w_res)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    ops_d       = ops_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    w_load      = 1'b0;
    w_dload     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_any) begin
          req0_ready = ~w_sel;
          req1_ready = w_sel;
          w_load     = 1'b1;
          gnt_d      = w_sel;
          last_d     = w_sel;
          cnt_d      = c_cnt_w'(MUL_LAT - 1);
          state_d    = ST_MUL;
        end
      end

      ST_MUL: begin
        // On the final multiply cycle the core output already holds the
        // result, so it is captured into the response register here.
        if (cnt_q == '0) begin
          w_dload = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - c_cnt_w'(1);
        end
      end

      ST_RESP: begin
        resp0_valid = ~gnt_q;
        resp1_valid = gnt_q;
        if (gnt_q ? resp1_ready : resp0_ready) begin
          ops_d   = ops_q + c_ops_w'(1);
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;     // port 0 wins the first contention
      gnt_q    <= 1'b0;
      cnt_q    <= '0;
      ops_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      ops_q   <= ops_d;
      if (w_dload) begin
        if (gnt_q) begin
          rdata1_q <= w_res;
        end else begin
          rdata0_q <= w_res;
        end
      end
    end
  end

  assign resp0_data = rdata0_q;
  assign resp1_data = rdata1_q;
  assign ops_done   = ops_q;

endmodule : fxmul_arbiter
`default_nettype wire

// File: tb/tb_fxmul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fxmul_arbiter
//  Description : Self-checking bench for fxmul_arbiter. A transaction-level
//                reference (in-flight record, age in cycles, last-granted
//                port, per-port last result, completed count) predicts every
//                output each cycle; directed scenarios pin literal values.
//                Honours FXMUL_ARBITER_SAT_EN for the expected arithmetic.
//  Ports       : (none)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fxmul_arbiter;

  localparam int DW = 32;
  localparam int FB = 12;
  localparam int ML = 2;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0, rr0 = 1'b0, rr1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        rdy0, rdy1, vl0, vl1;
  logic [31:0] d0, d1;
  logic [15:0] ops;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  fxmul_arbiter #(.DATA_W(DW), .FRAC_BITS(FB), .MUL_LAT(ML)) dut (
    .clock       (clock),
    .reset       (rst_n),
    .req0_valid  (v0),
    .req0_ready  (rdy0),
    .req0_a      (a0),
    .req0_b      (b0),
    .req1_valid  (v1),
    .req1_ready  (rdy1),
    .req1_a      (a1),
    .req1_b      (b1),
    .resp0_valid (vl0),
    .resp0_ready (rr0),
    .resp0_data  (d0),
    .resp1_valid (vl1),
    .resp1_ready (rr1),
    .resp1_data  (d1),
    .ops_done    (ops)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Fixed-point product: floor(a*b / 2^FB), then wrap or clamp to 32 bits.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> FB;
`ifdef FXMUL_ARBITER_SAT_EN
    if (p > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (p < -64'sd2147483648) return 32'h8000_0000;
`endif
    return p[31:0];
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  bit          m_on = 1'b0;
  bit          m_busy;
  int          m_port;
  int          m_age;      // cycles elapsed since the grant edge
  logic [31:0] m_res;
  int          m_last;
  logic [31:0] m_data [2];
  logic [15:0] m_ops;
  bit          m_any;
  int          m_sel;
  bit          m_rv;

  always @(negedge clock) begin
    m_any = !m_busy && (v0 || v1);
    m_sel = (v0 && v1) ? (m_last == 0 ? 1 : 0) : (v1 ? 1 : 0);
    m_rv  = m_busy && (m_age >= ML + 1);
    if (m_on && rst_n) begin
      chk("model_req0_ready", {31'd0, rdy0}, {31'd0, m_any && m_sel == 0});
      chk("model_req1_ready", {31'd0, rdy1}, {31'd0, m_any && m_sel == 1});
      chk("model_resp0_valid", {31'd0, vl0}, {31'd0, m_rv && m_port == 0});
      chk("model_resp1_valid", {31'd0, vl1}, {31'd0, m_rv && m_port == 1});
      chk("model_resp0_data", d0, (m_rv && m_port == 0) ? m_res : m_data[0]);
      chk("model_resp1_data", d1, (m_rv && m_port == 1) ? m_res : m_data[1]);
      chk("model_ops_done", {16'd0, ops}, {16'd0, m_ops});
    end
    if (!rst_n) begin
      m_on      = 1'b1;
      m_busy    = 1'b0;
      m_port    = 0;
      m_age     = 0;
      m_res     = '0;
      m_last    = 1;
      m_data[0] = '0;
      m_data[1] = '0;
      m_ops     = '0;
    end else if (m_on) begin
      if (m_busy) begin
        if (m_rv && ((m_port == 0) ? rr0 : rr1)) begin
          m_busy         = 1'b0;
          m_ops          = m_ops + 16'd1;
          m_data[m_port] = m_res;
        end else begin
          m_age++;
        end
      end else if (m_any) begin
        m_busy = 1'b1;
        m_port = m_sel;
        m_age  = 1;
        m_last = m_sel;
        m_res  = (m_sel == 1) ? ref_mul(a1, b1) : ref_mul(a0, b0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h0000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h0000_1000;
      default: return $urandom;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    rst_n = 1'b1;
  endtask

  // One request on port p; checks response latency and data literally.
  task automatic run_one(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string nm);
    int          t_hs;
    int          t_v;
    bit          ok;
    logic [31:0] dat;
    t_hs = 0;
    t_v  = 0;
    dat  = '0;
    rr0  = 1'b1;
    rr1  = 1'b1;
    if (p == 0) begin v0 = 1'b1; a0 = a; b0 = b; end
    else        begin v1 = 1'b1; a1 = a; b1 = b; end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if (((p == 0) ? rdy0 : rdy1) === 1'b1) begin ok = 1'b1; t_hs = cyc; end
    end
    chk({nm, "_grant"}, {31'd0, ok}, 32'd1);
    @(posedge clock); #1;
    v0 = 1'b0;
    v1 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if (((p == 0) ? vl0 : vl1) === 1'b1) begin
        ok  = 1'b1;
        t_v = cyc;
        dat = (p == 0) ? d0 : d1;
      end
    end
    chk({nm, "_resp_seen"}, {31'd0, ok}, 32'd1);
    chk({nm, "_latency"}, t_v - t_hs, ML + 1);
    chk({nm, "_data"}, dat, exp);
    @(posedge clock); #1;
  endtask

  // ---------------- main sequence ----------------
  int          go [4];
  int          ng;
  int          nh;
  logic [31:0] held;
  bit          seen;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    rst_n = 1'b1;
    @(negedge clock);
    chk("reset_ops_done", {16'd0, ops}, 32'd0);
    chk("reset_resp0_valid", {31'd0, vl0}, 32'd0);
    chk("reset_resp1_valid", {31'd0, vl1}, 32'd0);
    chk("reset_resp0_data", d0, 32'd0);
    chk("reset_resp1_data", d1, 32'd0);
    @(posedge clock); #1;

    // Basic products on each port.
    run_one(0, 32'h0000_1000, 32'h0000_2000, 32'h0000_2000, "one_times_two");
    run_one(1, 32'hFFFF_F000, 32'h0000_3000, 32'hFFFF_D000, "neg_one_times_three");
`ifdef FXMUL_ARBITER_SAT_EN
    run_one(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "max_squared");
`else
    run_one(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFF0_0000, "max_squared");
`endif

    // Round-robin with both requesters asking continuously from reset.
    rr0 = 1'b1; rr1 = 1'b1;
    a0 = rand_op(); b0 = rand_op(); a1 = rand_op(); b1 = rand_op();
    rst_n = 1'b0;
    v0 = 1'b1; v1 = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) go[k] = -1;
    ng = 0;
    nh = 0;
    for (int i = 0; i < 100 && nh < 4; i++) begin
      @(negedge clock);
      if (ng < 4 && rdy0 === 1'b1) begin go[ng] = 0; ng++; end
      else if (ng < 4 && rdy1 === 1'b1) begin go[ng] = 1; ng++; end
      if ((vl0 === 1'b1 && rr0) || (vl1 === 1'b1 && rr1)) nh++;
    end
    chk("rr_handshakes", nh, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("rr_grant_%0d", k), go[k], k % 2);
    @(posedge clock); #1;
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clock);
    chk("rr_ops_done", {16'd0, ops}, 32'd4);

    // Back-pressure on port 0 while port 1 keeps asking.
    @(posedge clock); #1;
    do_reset();
    rr0 = 1'b0; rr1 = 1'b1;
    a0 = 32'h0000_3000; b0 = 32'hFFFF_E000;
    v0 = 1'b1; v1 = 1'b1; a1 = rand_op(); b1 = rand_op();
    @(negedge clock);
    chk("bp_grant0", {31'd0, rdy0}, 32'd1);
    @(posedge clock); #1;
    v0 = 1'b0;
    seen = 1'b0;
    held = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (vl0 === 1'b1) begin seen = 1'b1; held = d0; end
    end
    chk("bp_resp_seen", {31'd0, seen}, 32'd1);
    chk("bp_data", held, 32'hFFFF_A000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_valid_held", {31'd0, vl0}, 32'd1);
      chk("bp_data_stable", d0, 32'hFFFF_A000);
      chk("bp_no_grant1", {31'd0, rdy1}, 32'd0);
    end
    @(posedge clock); #1;
    rr0 = 1'b1;
    @(negedge clock);
    chk("bp_hs_cycle_no_grant1", {31'd0, rdy1}, 32'd0);
    @(negedge clock);
    chk("bp_grant1_after_hs", {31'd0, rdy1}, 32'd1);
    chk("bp_ops_done", {16'd0, ops}, 32'd1);
    @(posedge clock); #1;
    v1 = 1'b0;
    repeat (6) @(posedge clock);
    #1;

    // Reset in the middle of a multiply.
    do_reset();
    rr0 = 1'b1;
    v0 = 1'b1; a0 = 32'h0000_2000; b0 = 32'h0000_2000;
    @(negedge clock);
    chk("mr_grant0", {31'd0, rdy0}, 32'd1);
    @(posedge clock); #1;
    v0 = 1'b0;
    rst_n = 1'b0;
    @(posedge clock); #1;
    rst_n = 1'b1;
    v0 = 1'b1; a0 = 32'h0000_1000; b0 = 32'h0000_1000;
    @(negedge clock);
    chk("mr_idle_after_reset", {31'd0, rdy0}, 32'd1);
    chk("mr_no_resp", {31'd0, vl0}, 32'd0);
    chk("mr_ops_done", {16'd0, ops}, 32'd0);
    @(posedge clock); #1;
    v0 = 1'b0;
    repeat (6) @(posedge clock);
    #1;

    // Randomised traffic, checked cycle by cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      v0  = ($urandom_range(0, 3) != 0);
      v1  = ($urandom_range(0, 3) != 0);
      rr0 = ($urandom_range(0, 2) != 0);
      rr1 = ($urandom_range(0, 2) != 0);
      a0 = rand_op(); b0 = rand_op();
      a1 = rand_op(); b1 = rand_op();
      @(posedge clock); #1;
    end
    rst_n = 1'b1;
    v0 = 1'b0; v1 = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule : tb_fxmul_arbiter
`default_nettype wire

// File: doc/fxmul_arbiter.md
FXMUL_ARBITER -- requirements
Module: fxmul_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter FRAC_BITS, default 12, fixed-point fraction bits discarded from the product.
REQ-003 SHALL have parameter MUL_LAT, default 2, multiplier register stages, legal range 1..4.
REQ-004 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-low.
REQ-006 SHALL have ports reqN_valid, input, 1, and reqN_ready, output, 1, for N=0,1: request handshake.
REQ-007 SHALL have ports reqN_a and reqN_b, input, DATA_W, signed operands, for N=0,1.
REQ-008 SHALL have ports respN_valid, output, 1, and respN_ready, input, 1, for N=0,1: response handshake.
REQ-009 SHALL have port respN_data, output, DATA_W, signed result, for N=0,1.
REQ-010 SHALL have port ops_done, output, 16, count of completed responses, wrapping.

Function
REQ-011 SHALL share one signed DATA_W x DATA_W multiplier between the two requesters, with at most one operation in flight.
REQ-012 SHALL implement the FSM IDLE -> MUL -> RESP -> IDLE.
REQ-013 SHALL, in IDLE, grant one valid requester combinationally: reqN_ready=1 only for the granted port; both ready=0 outside IDLE.
REQ-014 SHALL arbitrate round-robin: when both requesters are valid, the port not granted last wins; the pointer updates only on a grant.
REQ-015 SHALL, on handshake at cycle T, latch the operands and the grant index and enter MUL.
REQ-016 SHALL stay in MUL exactly MUL_LAT cycles, counted by a down-counter, then enter RESP.
REQ-017 SHALL hold respN_valid=1 on the granted port only, from cycle T+MUL_LAT+1 until respN_ready=1.
REQ-018 SHALL keep respN_data stable while respN_valid=1.
REQ-019 SHALL hold respN_data at its last value while respN_valid=0.
REQ-020 SHALL form result = (2*DATA_W-bit signed product) arithmetically shifted right by FRAC_BITS, i.e. floor, then truncated to the low DATA_W bits.
REQ-021 SHALL, on a response handshake, return to IDLE and increment ops_done, wrapping from 0xFFFF to 0x0000.
REQ-022 SHALL leave ops_done unchanged in every cycle without a response handshake.
REQ-023 SHALL permit a new grant in the cycle after a response handshake, not in the same cycle.
REQ-024 SHALL ignore the respN_ready input of the non-granted port.
REQ-025 SHALL ignore all respN_ready inputs outside RESP.
REQ-026 SHALL treat a reqN_valid deasserted before its grant as a withdrawn request, with no side effects.

Reset
REQ-027 SHALL, while reset=0 at a clock edge, force state IDLE, grant pointer favouring port 0, counter 0, ops_done=0, respN_valid=0 and respN_data=0.
REQ-028 SHALL, on reset asserted mid-operation (MUL or RESP), discard the in-flight operation with no response.

Configuration
REQ-029 SHALL, with macro FXMUL_ARBITER_SAT_EN defined, saturate shifted results above the signed DATA_W maximum to 0x7FFFFFFF and below the minimum to 0x80000000.
REQ-030 SHALL, with FXMUL_ARBITER_SAT_EN undefined, use wrap truncation per REQ-020 and include no saturation logic.

Structure
REQ-031 SHALL place the FSM state enum, the default DATA_W/FRAC_BITS/MUL_LAT constants and the 16-bit counter width in shared package fxmul_pkg.
REQ-032 SHALL implement the pipelined multiplier, shift and optional saturation as sub-module fxmul_core (operands in, MUL_LAT-stage result out).

Verification
REQ-033 SHALL cover: req0 a=0x00001000, b=0x00002000 -> resp0_data=0x00002000 with resp0_valid at T+3 (MUL_LAT=2).
REQ-034 SHALL cover: req1 a=0xFFFFF000, b=0x00003000 -> resp1_data=0xFFFFD000.
REQ-035 SHALL cover: a=b=0x7FFFFFFF -> 0xFFF00000 without FXMUL_ARBITER_SAT_EN, and 0x7FFFFFFF with it.
REQ-036 SHALL cover: both requests valid continuously from reset -> grant order 0,1,0,1, with ops_done=4 after four response handshakes.
REQ-037 SHALL cover: resp0_ready held 0 for 5 cycles -> resp0_valid and resp0_data stable, no grant to req1 until the handshake.
REQ-038 SHALL cover: reset=0 asserted during MUL -> no response, IDLE next cycle, ops_done=0.
